// File: rtl/deserializador_pkg.sv
// Shared types and constants for the comma-aligned deserializer family.
// The comma detector is reused by the transmitter-side checker.
package deserializador_pkg;

    localparam int CNT_W = 4;

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        BUSCANDO      = 2'd0,
        SINCRONIZANDO = 2'd1,
        ALINEADO      = 2'd2
    } estado_t;

endpackage

// File: rtl/deserializador_alineado_detector.sv
// Combinational comma detector: flags a word equal to COMMA in either
// running disparity (the pattern or its bitwise complement).
module detector_comma #(
    parameter int unsigned      WIDTH = 10,
    parameter logic [WIDTH-1:0] COMMA = 10'b0011111010
) (
    input  logic [WIDTH-1:0] palabra,
    output logic             hit
);

    assign hit = (palabra == COMMA) || (palabra == ~COMMA);

endmodule

// File: rtl/deserializador_alineado.sv
// Serial-to-parallel receiver that finds word boundaries by comma detection,
// declares lock after LOCK_COUNT boundary commas and drops it after LOSS_LIMIT
// misaligned commas.
//
//   state         | meaning
//   BUSCANDO      | hunting for any comma in the bit stream
//   SINCRONIZANDO | comma seen; confirming commas land on the boundary
//   ALINEADO      | locked; one word emitted per boundary
module deserializador_alineado
    import deserializador_pkg::*;
#(
    parameter int unsigned      WIDTH      = 10,
    parameter logic [WIDTH-1:0] COMMA      = K28_5_RDN,
    parameter int unsigned      LOCK_COUNT = 4,
    parameter int unsigned      LOSS_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             entrada,
    output logic [WIDTH-1:0] salidas,
    output logic             valido,
    output logic             es_comma,
    output logic             alineado
);

    estado_t          state_q, state_d;
    logic [WIDTH-1:0] sr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_comma_q, cnt_comma_d;
    logic [CNT_W-1:0] cnt_err_q, cnt_err_d;
    logic             hit;
    logic             frontera;
    logic             captura;

    detector_comma #(
        .WIDTH (WIDTH),
        .COMMA (COMMA)
    ) u_detector (
        .palabra (sr_q),
        .hit     (hit)
    );

    assign frontera = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == CNT_W'(WIDTH - 1)) ? '0 : cnt_q + 1'b1;
        cnt_comma_d = cnt_comma_q;
        cnt_err_d   = cnt_err_q;
        captura     = 1'b0;

        case (state_q)
            BUSCANDO: begin
                // The comma just found defines phase 0, so the next edge is phase 1.
                if (hit) begin
                    cnt_d       = CNT_W'(1);
                    cnt_comma_d = CNT_W'(1);
                    if (LOCK_COUNT == 1) begin
                        state_d   = ALINEADO;
                        cnt_err_d = '0;
                    end else begin
                        state_d = SINCRONIZANDO;
                    end
                end
            end
            SINCRONIZANDO: begin
                if (frontera) begin
                    if (hit) begin
                        cnt_comma_d = cnt_comma_q + 1'b1;
                        if ((cnt_comma_q + 1'b1) == CNT_W'(LOCK_COUNT)) begin
                            state_d   = ALINEADO;
                            cnt_err_d = '0;
                        end
                    end else begin
                        state_d     = BUSCANDO;
                        cnt_comma_d = '0;
                    end
                end
            end
            ALINEADO: begin
                // A boundary comma wins over error counting.
                if (frontera) begin
                    captura = 1'b1;
                    if (hit) begin
                        cnt_err_d = '0;
                    end
                end else if (hit) begin
                    cnt_err_d = cnt_err_q + 1'b1;
                    if ((cnt_err_q + 1'b1) == CNT_W'(LOSS_LIMIT)) begin
                        state_d     = BUSCANDO;
                        cnt_comma_d = '0;
                    end
                end
            end
            default: begin
                state_d     = BUSCANDO;
                cnt_comma_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BUSCANDO;
            sr_q        <= '0;
            cnt_q       <= '0;
            cnt_comma_q <= '0;
            cnt_err_q   <= '0;
            salidas     <= '0;
            valido      <= 1'b0;
            es_comma    <= 1'b0;
            alineado    <= 1'b0;
        end else if (enb) begin
            state_q     <= state_d;
            sr_q        <= {sr_q[WIDTH-2:0], entrada};
            cnt_q       <= cnt_d;
            cnt_comma_q <= cnt_comma_d;
            cnt_err_q   <= cnt_err_d;
            valido      <= captura;
            es_comma    <= captura & hit;
            alineado    <= (state_d == ALINEADO);
            if (captura) begin
                salidas <= sr_q;
            end
        end else begin
            valido   <= 1'b0;
            es_comma <= 1'b0;
        end
    end

endmodule

// File: doc/deserializador_alineado.md
Name: deserializador_alineado

Overview:
- Parametrised serial-to-parallel receiver; next generation of the team's serialParalelo block.
- Consumes the one-bit line driven by the paralelo-serial emitter, MSB first, one bit per enabled `clk` cycle.
- Finds word boundaries by comma detection instead of relying on an external `clk10`.
- Reports lock status and flags comma words, replacing the fixed-phase capture used in earlier generations.

Parameters:
- WIDTH, 10: symbol width in bits.
- COMMA, 10'b0011111010: alignment symbol (K28.5 RD-). Its bitwise complement (RD+) also matches. Width equals WIDTH.
- LOCK_COUNT, 4: consecutive boundary commas needed to declare lock, counting the first detection. Range 1..15.
- LOSS_LIMIT, 3: misaligned commas tolerated while locked before lock is dropped. Range 1..15.

Ports:
- clk  in  1  bit clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- enb  in  1  clock enable; when low, all state holds.
- entrada  in  1  serial data, MSB first.
- salidas  out  WIDTH  last aligned word.
- valido  out  1  one-cycle pulse when `salidas` updates.
- es_comma  out  1  qualifies `salidas`; high when the word equals COMMA or ~COMMA.
- alineado  out  1  high while state is ALINEADO.

Behaviour:
- Reset (async, rst=1):
  - `sr` (WIDTH-bit shift register), `salidas`, `valido`, `es_comma` = 0.
  - State = BUSCANDO; `cnt`, `cnt_comma`, `cnt_err` = 0; `alineado` = 0.
  - Reset asserted mid-word or mid-lock discards everything; no output is produced for the partial word.
- enb=0: no register changes, except `valido` and `es_comma`, which are forced to 0 at the next edge.
- Shift: each enabled edge, sr <= {sr[WIDTH-2:0], entrada}.
- `hit` (combinational) = (sr==COMMA) | (sr==~COMMA).
- `cnt` is the bit phase, 0..WIDTH-1. Each enabled edge it increments, wrapping WIDTH-1 -> 0. A boundary is a cycle with cnt==0.
- BUSCANDO:
  - `cnt` is ignored.
  - On hit: next edge sets cnt<=1, cnt_comma<=1, state<=SINCRONIZANDO.
  - If LOCK_COUNT==1, the state goes directly to ALINEADO instead.
- SINCRONIZANDO, at a boundary:
  - hit: cnt_comma+1. When the new value equals LOCK_COUNT, state<=ALINEADO and cnt_err<=0.
  - no hit: state<=BUSCANDO and cnt_comma<=0.
  - A hit at a non-boundary cycle is ignored. No `valido` in this state.
- ALINEADO, at a boundary:
  - Next edge: salidas<=sr, valido<=1, es_comma<=hit.
  - If hit, cnt_err<=0.
  - Output latency: one `clk` after the word's last bit is shifted into `sr`.
- ALINEADO, misaligned comma (hit at cnt!=0):
  - cnt_err+1. When the new value equals LOSS_LIMIT, state<=BUSCANDO, cnt_comma<=0, and `alineado` falls at that edge.
  - The misaligned comma does not relock immediately; it needs a fresh hit in BUSCANDO.
- Simultaneous events: in ALINEADO, a boundary hit takes priority over error counting, so it is never also counted as misaligned.
- Between boundaries: `valido` is 0, and `salidas` holds its last value.
- `alineado` is registered, equal to (state==ALINEADO).

Decomposition:
- Package `deserializador_pkg`:
  - state encoding: BUSCANDO=2'd0, SINCRONIZANDO=2'd1, ALINEADO=2'd2.
  - K28_5_RDN=10'b0011111010 and K28_5_RDP=10'b1100000101.
  - counter width constant: 4 bits.
- Sub-module `detector_comma`:
  - purely combinational.
  - parameters WIDTH and COMMA; input `palabra`, output `hit`.
  - reused later by the transmitter-side checker.

Test Plan (all with defaults, enb=1 unless stated):
- Lock: rst for 5 clk; 3 random bits; then 4×COMMA; then 10'b1000011111 and 10'b0111111110 -> `alineado` rises at the 4th comma boundary; `valido` pulses exactly every 10 clk; `salidas`=10'b1000011111 with es_comma=0, then 10'b0111111110.
- Disparity: alternate COMMA and 10'b1100000101 ×4, then 10'b1100101100 -> lock achieved; first output 10'b1100101100; later comma words flagged es_comma=1.
- Failed sync: COMMA, COMMA, 10'b0000011111, COMMA… -> state returns to BUSCANDO after the third word; `alineado` stays 0 until 4 further consecutive commas.
- Loss of lock: lock as in the lock scenario; then slip the stream by 3 bits and send COMMA ×3 -> cnt_err counts 1, 2, 3; `alineado` falls at the 3rd misaligned comma; no `valido` afterwards until relock.
- Enable gating: while locked, hold enb=0 for 7 clk mid-word -> no `valido`, outputs frozen; after enb=1 the word completes intact with the correct value 10'b1111100000.
- Async reset mid-lock: assert rst between edges while locked -> all outputs 0 immediately, before the next clk edge; relock requires 4 commas.
